// File: rtl/cd_config_feeder.sv
// Host-to-CD configuration write feeder: a small FIFO followed by a registered valid/ready output stage.
// Optional macro CD_BOOT_DEFAULTS_EN replays four fixed boot writes before any host traffic.
module cd_config_feeder #(
  parameter int WIDTH_CONFIG_ADDR = 4,
  parameter int WIDTH_CONFIG_DATA = 16,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [WIDTH_CONFIG_ADDR-1:0]       h_addr,
  input  logic [WIDTH_CONFIG_DATA-1:0]       h_data,
  input  logic                               h_valid,
  output logic                               h_ready,
  output logic [WIDTH_CONFIG_ADDR-1:0]       c_addr,
  output logic [WIDTH_CONFIG_DATA-1:0]       c_data,
  output logic                               c_valid,
  input  logic                               c_ready,
  output logic [$clog2(FIFO_DEPTH):0]        level,
  output logic                               busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CA = WIDTH_CONFIG_ADDR;
  localparam int CD = WIDTH_CONFIG_DATA;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    BOOT = 2'd2
  } state_t;

`ifdef CD_BOOT_DEFAULTS_EN
  localparam state_t RESET_STATE = BOOT;
`else
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t              state_q;
  logic [AW:0]         wptr_q;
  logic [AW:0]         rptr_q;
  logic [LW-1:0]       level_q;
  logic [CA+CD-1:0]    mem_q [FIFO_DEPTH];
  logic                c_valid_q;
  logic [CA-1:0]       c_addr_q;
  logic [CD-1:0]       c_data_q;

  logic                full_s;
  logic                empty_s;
  logic                push_s;
  logic                pop_s;
  logic [CA+CD-1:0]    rd_word_s;

`ifdef CD_BOOT_DEFAULTS_EN
  logic [1:0]          boot_idx_q;

  function automatic logic [CA-1:0] boot_addr(input logic [1:0] idx);
    return CA'(idx);
  endfunction

  function automatic logic [CD-1:0] boot_data(input logic [1:0] idx);
    case (idx)
      2'd0:    return CD'(16'd2);
      2'd1:    return CD'(16'd434);
      2'd2:    return CD'(16'd25000);
      2'd3:    return CD'(16'd50000);
      default: return CD'(16'd0);
    endcase
  endfunction
`endif

  // Wrap bit distinguishes full from empty when the index bits match.
  assign full_s    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_s   = (wptr_q == rptr_q);
  assign push_s    = h_valid && !full_s;
  assign rd_word_s = mem_q[rptr_q[AW-1:0]];

  assign h_ready = !full_s;
  assign c_addr  = c_addr_q;
  assign c_data  = c_data_q;
  assign c_valid = c_valid_q;
  assign level   = level_q;
  assign busy    = (level_q != {LW{1'b0}}) || c_valid_q || (state_q != IDLE);

  always_comb begin
    pop_s = 1'b0;
    case (state_q)
      IDLE:    pop_s = !empty_s;
      SEND:    pop_s = c_ready && !empty_s;
`ifdef CD_BOOT_DEFAULTS_EN
      BOOT:    pop_s = c_valid_q && c_ready && (boot_idx_q == 2'd3) && !empty_s;
`endif
      default: pop_s = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wptr_q[AW-1:0]] <= {h_addr, h_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= {LW{1'b0}};
      rptr_q  <= {LW{1'b0}};
      level_q <= {LW{1'b0}};
    end else begin
      if (push_s) wptr_q <= wptr_q + LW'(1);
      if (pop_s)  rptr_q <= rptr_q + LW'(1);
      case ({push_s, pop_s})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Output stage only reloads on a handshake or when empty, so a stalled word holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RESET_STATE;
      c_valid_q  <= 1'b0;
      c_addr_q   <= {CA{1'b0}};
      c_data_q   <= {CD{1'b0}};
`ifdef CD_BOOT_DEFAULTS_EN
      boot_idx_q <= 2'd0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (pop_s) begin
            {c_addr_q, c_data_q} <= rd_word_s;
            c_valid_q            <= 1'b1;
            state_q              <= SEND;
          end
        end
        SEND: begin
          if (c_ready) begin
            if (pop_s) begin
              {c_addr_q, c_data_q} <= rd_word_s;
            end else begin
              c_valid_q <= 1'b0;
              state_q   <= IDLE;
            end
          end
        end
`ifdef CD_BOOT_DEFAULTS_EN
        BOOT: begin
          if (!c_valid_q) begin
            c_valid_q <= 1'b1;
            c_addr_q  <= boot_addr(boot_idx_q);
            c_data_q  <= boot_data(boot_idx_q);
          end else if (c_ready) begin
            if (boot_idx_q == 2'd3) begin
              boot_idx_q <= 2'd0;
              if (pop_s) begin
                {c_addr_q, c_data_q} <= rd_word_s;
                state_q              <= SEND;
              end else begin
                c_valid_q <= 1'b0;
                state_q   <= IDLE;
              end
            end else begin
              boot_idx_q <= boot_idx_q + 2'd1;
              c_addr_q   <= boot_addr(boot_idx_q + 2'd1);
              c_data_q   <= boot_data(boot_idx_q + 2'd1);
            end
          end
        end
`endif
        default: begin
          state_q   <= IDLE;
          c_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cd_config_feeder.sv
// Directed self-checking bench for cd_config_feeder (default build, boot defaults disabled).
module tb_cd_config_feeder;

  logic        clk;
  logic        rst;
  logic [3:0]  h_addr;
  logic [15:0] h_data;
  logic        h_valid;
  logic        h_ready;
  logic [3:0]  c_addr;
  logic [15:0] c_data;
  logic        c_valid;
  logic        c_ready;
  logic [2:0]  level;
  logic        busy;

  int vectors;
  int miscompares;

  cd_config_feeder #(
    .WIDTH_CONFIG_ADDR(4),
    .WIDTH_CONFIG_DATA(16),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .h_addr(h_addr), .h_data(h_data), .h_valid(h_valid), .h_ready(h_ready),
    .c_addr(c_addr), .c_data(c_data), .c_valid(c_valid), .c_ready(c_ready),
    .level(level), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; h_valid = 1'b0; h_addr = 4'd0; h_data = 16'd0; c_ready = 1'b0;
    #3;
    vectors++;
    if ({c_valid, level, busy, c_addr, c_data} !== 25'd0) begin
      $display("FAIL reset_outputs: got v=%b lvl=%0d busy=%b a=%h d=%h, expected all zero",
               c_valid, level, busy, c_addr, c_data);
      miscompares++;
    end
    vectors++;
    if (h_ready !== 1'b1) begin
      $display("FAIL reset_h_ready: got %b expected 1", h_ready);
      miscompares++;
    end
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_single_write();
    c_ready = 1'b1;
    h_addr = 4'd1; h_data = 16'h01B2; h_valid = 1'b1;
    tick();
    h_valid = 1'b0;
    vectors++;
    if ({c_valid, level} !== {1'b0, 3'd1}) begin
      $display("FAIL single_n1: got v=%b lvl=%0d expected v=0 lvl=1", c_valid, level);
      miscompares++;
    end
    tick();
    vectors++;
    if ({c_valid, c_addr, c_data, level} !== {1'b1, 4'd1, 16'h01B2, 3'd0}) begin
      $display("FAIL single_n2: got v=%b a=%h d=%h lvl=%0d expected v=1 a=1 d=01b2 lvl=0",
               c_valid, c_addr, c_data, level);
      miscompares++;
    end
    tick();
    vectors++;
    if ({c_valid, busy, level} !== {1'b0, 1'b0, 3'd0}) begin
      $display("FAIL single_n3: got v=%b busy=%b lvl=%0d expected 0/0/0", c_valid, busy, level);
      miscompares++;
    end
  endtask

  task automatic test_stall_hold();
    c_ready = 1'b0;
    h_addr = 4'd2; h_data = 16'h1111; h_valid = 1'b1;
    tick();
    h_addr = 4'd3; h_data = 16'h2222;
    tick();
    h_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if ({c_valid, c_addr, c_data, level} !== {1'b1, 4'd2, 16'h1111, 3'd1}) begin
        $display("FAIL stall_hold[%0d]: got v=%b a=%h d=%h lvl=%0d expected v=1 a=2 d=1111 lvl=1",
                 i, c_valid, c_addr, c_data, level);
        miscompares++;
      end
      tick();
    end
    c_ready = 1'b1;
    tick();
    vectors++;
    if ({c_valid, c_addr, c_data, level} !== {1'b1, 4'd3, 16'h2222, 3'd0}) begin
      $display("FAIL stall_second: got v=%b a=%h d=%h lvl=%0d expected v=1 a=3 d=2222 lvl=0",
               c_valid, c_addr, c_data, level);
      miscompares++;
    end
    tick();
    vectors++;
    if (c_valid !== 1'b0) begin
      $display("FAIL stall_end: got c_valid=%b expected 0", c_valid);
      miscompares++;
    end
  endtask

  task automatic test_full();
    logic [19:0] exp_w [5];
    for (int i = 0; i < 5; i++) exp_w[i] = {4'(i + 4), 16'hA000 + 16'(i)};
    c_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      {h_addr, h_data} = exp_w[i];
      h_valid = 1'b1;
      tick();
    end
    h_valid = 1'b0;
    vectors++;
    if ({level, h_ready} !== {3'd4, 1'b0}) begin
      $display("FAIL full_level: got lvl=%0d h_ready=%b expected lvl=4 h_ready=0", level, h_ready);
      miscompares++;
    end
    h_addr = 4'hF; h_data = 16'hDEAD; h_valid = 1'b1;
    tick();
    h_valid = 1'b0;
    vectors++;
    if ({level, h_ready, c_valid, c_addr, c_data} !== {3'd4, 1'b0, 1'b1, exp_w[0]}) begin
      $display("FAIL full_refuse: got lvl=%0d h_ready=%b v=%b a=%h d=%h expected lvl=4 h_ready=0 v=1 w=%h",
               level, h_ready, c_valid, c_addr, c_data, exp_w[0]);
      miscompares++;
    end
    c_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({c_valid, c_addr, c_data} !== {1'b1, exp_w[i]}) begin
        $display("FAIL full_drain[%0d]: got v=%b a=%h d=%h expected v=1 w=%h",
                 i, c_valid, c_addr, c_data, exp_w[i]);
        miscompares++;
      end
      tick();
    end
    vectors++;
    if ({c_valid, level, h_ready} !== {1'b0, 3'd0, 1'b1}) begin
      $display("FAIL full_end: got v=%b lvl=%0d h_ready=%b expected 0/0/1", c_valid, level, h_ready);
      miscompares++;
    end
  endtask

  task automatic test_reset_mid();
    c_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      h_addr = 4'(i + 8); h_data = 16'hB000 + 16'(i); h_valid = 1'b1;
      tick();
    end
    h_valid = 1'b0;
    vectors++;
    if ({c_valid, level} !== {1'b1, 3'd3}) begin
      $display("FAIL rstmid_pre: got v=%b lvl=%0d expected v=1 lvl=3", c_valid, level);
      miscompares++;
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({c_valid, level, h_ready} !== {1'b0, 3'd0, 1'b1}) begin
      $display("FAIL rstmid_async: got v=%b lvl=%0d h_ready=%b expected 0/0/1", c_valid, level, h_ready);
      miscompares++;
    end
    tick();
    rst = 1'b0;
    c_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if ({c_valid, level, busy} !== {1'b0, 3'd0, 1'b0}) begin
        $display("FAIL rstmid_stale[%0d]: got v=%b lvl=%0d busy=%b expected 0/0/0", i, c_valid, level, busy);
        miscompares++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [19:0] exp_q [$];
    int k;
    c_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      {h_addr, h_data} = {4'(i), 16'hC000 + 16'(i)};
      exp_q.push_back({h_addr, h_data});
      h_valid = 1'b1;
      tick();
    end
    h_valid = 1'b0;
    vectors++;
    if ({c_valid, level} !== {1'b1, 3'd2}) begin
      $display("FAIL b2b_setup: got v=%b lvl=%0d expected v=1 lvl=2", c_valid, level);
      miscompares++;
    end
    c_ready = 1'b1;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      {h_addr, h_data} = {4'(15 - i), 16'hD000 + 16'(i)};
      h_valid = 1'b1;
      vectors++;
      if ({c_valid, c_addr, c_data} !== {1'b1, exp_q[k]}) begin
        $display("FAIL b2b_out[%0d]: got v=%b a=%h d=%h expected v=1 w=%h", k, c_valid, c_addr, c_data, exp_q[k]);
        miscompares++;
      end
      exp_q.push_back({h_addr, h_data});
      k++;
      tick();
      vectors++;
      if (level !== 3'd2) begin
        $display("FAIL b2b_level[%0d]: got %0d expected 2", i, level);
        miscompares++;
      end
    end
    h_valid = 1'b0;
    while (k < exp_q.size()) begin
      vectors++;
      if ({c_valid, c_addr, c_data} !== {1'b1, exp_q[k]}) begin
        $display("FAIL b2b_out[%0d]: got v=%b a=%h d=%h expected v=1 w=%h", k, c_valid, c_addr, c_data, exp_q[k]);
        miscompares++;
      end
      k++;
      tick();
    end
    vectors++;
    if ({c_valid, level, busy} !== {1'b0, 3'd0, 1'b0}) begin
      $display("FAIL b2b_end: got v=%b lvl=%0d busy=%b expected 0/0/0", c_valid, level, busy);
      miscompares++;
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_single_write();
    test_stall_hold();
    test_full();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
